output_fill_multi: RTL and testbench

//  Parametrised output-feature-map writer for the CNN datapath. Accepts one beat per

---
 rtl/output_fill_multi.sv | 158 +++++++++++++++
 tb/tb_output_fill_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_fill_multi.sv
// Output feature-map writer: accepts one NUM_CH-wide beat per pixel, applies optional ReLU,
// and serialises the channels to base + ch*stride + pixel, one registered write per cycle.
module output_fill_multi #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 4,
  parameter int SIZE_W = 8
) (
  input  logic                     w_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_address,
  input  logic [SIZE_W-1:0]        featuremap_size,
  input  logic [ADDR_W-1:0]        channel_stride,
  input  logic                     relu_en,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     write_enable,
  output logic [ADDR_W-1:0]        c_address,
  output logic [DATA_W-1:0]        w_data,
  output logic                     busy,
  output logic                     done,
  output logic                     addr_wrap
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = ADDR_W + CH_W + SIZE_W + 2;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [SIZE_W-1:0]        pixel_q, pixel_d;
  logic [SIZE_W-1:0]        size_q, size_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [ADDR_W-1:0]        stride_q, stride_d;
  logic                     relu_q, relu_d;
  logic [NUM_CH*DATA_W-1:0] hold_q, hold_d;
  logic                     in_ready_q, in_ready_d;
  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     wrap_q, wrap_d;
  logic [DATA_W-1:0]        sel;
  logic [SUM_W-1:0]         sum;

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      pixel_q    <= '0;
      size_q     <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      relu_q     <= 1'b0;
      hold_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      pixel_q    <= pixel_d;
      size_q     <= size_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      relu_q     <= relu_d;
      hold_q     <= hold_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    pixel_d  = pixel_q;
    size_d   = size_q;
    base_d   = base_q;
    stride_d = stride_q;
    relu_d   = relu_q;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_address;
          stride_d = channel_stride;
          size_d   = featuremap_size;
          relu_d   = relu_en;
          pixel_d  = '0;
          ch_d     = '0;
          state_d  = (featuremap_size == '0) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (in_valid && in_ready_q) begin
          hold_d  = in_data;
          ch_d    = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_d    = '0;
          pixel_d = pixel_q + SIZE_W'(1);
          state_d = ({1'b0, pixel_q} + (SIZE_W+1)'(1) == {1'b0, size_q}) ? DONE : ACCEPT;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded from the next-state values so each write lands one cycle after its decision.
  always_comb begin
    in_ready_d = (state_d == ACCEPT);
    busy_d     = (state_d == ACCEPT) || (state_d == WRITE);
    done_d     = (state_d == DONE);
    we_d       = (state_d == WRITE);
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wrap_d     = wrap_q;
    sel        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_d == CH_W'(c)) sel = hold_d[c*DATA_W +: DATA_W];
    end
    sum = SUM_W'(base_d) + SUM_W'(ch_d) * SUM_W'(stride_d) + SUM_W'(pixel_d);
    if (state_q == IDLE && start) wrap_d = 1'b0;
    if (we_d) begin
      addr_d  = sum[ADDR_W-1:0];
      wdata_d = (relu_d && sel[DATA_W-1]) ? '0 : sel;
      if (|sum[SUM_W-1:ADDR_W]) wrap_d = 1'b1;
    end
  end

  assign in_ready     = in_ready_q;
  assign write_enable = we_q;
  assign c_address    = addr_q;
  assign w_data       = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign addr_wrap    = wrap_q;

endmodule

// File: tb/tb_output_fill_multi.sv
// Self-checking bench for output_fill_multi: vector table, hand-written corner sequences,
// and randomized fills compared against a pixel/channel loop reference model.
module tb_output_fill_multi;

  logic        w_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_address;
  logic [7:0]  featuremap_size;
  logic [9:0]  channel_stride;
  logic        relu_en;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        write_enable;
  logic [9:0]  c_address;
  logic [15:0] w_data;
  logic        busy;
  logic        done;
  logic        addr_wrap;

  int checks = 0;
  int fails  = 0;
  int doneCount;
  int readyCount;
  logic [25:0] capQ[$];
  logic [9:0]  expAddrQ[$];
  logic [15:0] expDataQ[$];
  logic        expWrap;

  typedef struct packed {
    logic [9:0]        base;
    logic [9:0]        stride;
    logic [7:0]        size;
    logic              relu;
    logic [7:0][63:0]  beats;
    logic [7:0][9:0]   expAddr;
    logic [7:0][15:0]  expData;
    logic              expWrapBit;
  } vecT;

  vecT vecs[4];

  output_fill_multi #(.DATA_W(16), .ADDR_W(10), .NUM_CH(4), .SIZE_W(8)) dut (
    .w_clk(w_clk), .reset(reset), .start(start), .base_address(base_address),
    .featuremap_size(featuremap_size), .channel_stride(channel_stride), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .write_enable(write_enable),
    .c_address(c_address), .w_data(w_data), .busy(busy), .done(done), .addr_wrap(addr_wrap)
  );

  always #5 w_clk = ~w_clk;

  always @(negedge w_clk) begin
    if (write_enable) capQ.push_back({c_address, w_data});
    if (done) doneCount++;
    if (in_ready) readyCount++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic buildExpected(input logic [9:0] b, input logic [9:0] s, input logic [7:0] sz,
                               input logic r, input logic [7:0][63:0] beats);
    int sAddr;
    logic signed [15:0] v;
    expAddrQ.delete();
    expDataQ.delete();
    expWrap = 1'b0;
    for (int p = 0; p < int'(sz); p++) begin
      for (int c = 0; c < 4; c++) begin
        sAddr = int'(b) + c * int'(s) + p;
        if (sAddr >= 1024) expWrap = 1'b1;
        expAddrQ.push_back(10'(sAddr % 1024));
        v = beats[p][c*16 +: 16];
        expDataQ.push_back((r && v < 0) ? 16'h0000 : v);
      end
    end
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, "_writeCount"}, capQ.size(), expAddrQ.size());
    n = (capQ.size() < expAddrQ.size()) ? capQ.size() : expAddrQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_addr"}, capQ[i][25:16], expAddrQ[i]);
      checkOutput({tag, "_data"}, capQ[i][15:0], expDataQ[i]);
    end
    checkOutput({tag, "_addrWrap"}, addr_wrap, expWrap);
    checkOutput({tag, "_doneOnce"}, doneCount, 1);
  endtask

  task automatic applyStimulus(input logic [9:0] b, input logic [9:0] s, input logic [7:0] sz,
                               input logic r, input logic [7:0][63:0] beats,
                               input int stall, input bit poke);
    int t;
    capQ.delete();
    doneCount  = 0;
    readyCount = 0;
    @(negedge w_clk);
    base_address = b; channel_stride = s; featuremap_size = sz; relu_en = r; start = 1'b1;
    @(negedge w_clk);
    start = 1'b0;
    for (int p = 0; p < int'(sz); p++) begin
      t = 0;
      while (!in_ready && t < 20) begin @(negedge w_clk); t++; end
      if (!in_ready) begin
        checkOutput("readyTimeout", 0, 1);
        return;
      end
      if (p == 0 && stall > 0) begin
        repeat (stall) begin
          checkOutput("stallReady", in_ready, 1);
          @(negedge w_clk);
        end
        checkOutput("stallNoWrites", capQ.size(), 0);
      end
      in_valid = 1'b1;
      in_data  = beats[p];
      @(negedge w_clk);
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      if (poke && p == 0) begin
        checkOutput("pokeInWrite", write_enable, 1);
        base_address = b + 10'h155; channel_stride = s + 10'h3; featuremap_size = sz + 8'd3;
        relu_en = ~r; start = 1'b1;
        @(negedge w_clk);
        start = 1'b0;
      end
    end
    t = 0;
    while (doneCount == 0 && t < 40) begin @(negedge w_clk); t++; end
    checkOutput("doneSeen", (doneCount > 0) ? 1 : 0, 1);
    repeat (3) @(negedge w_clk);
  endtask

  initial begin
    logic [7:0][63:0] bts;
    int t;
    reset = 1'b1; start = 1'b0; base_address = '0; featuremap_size = '0; channel_stride = '0;
    relu_en = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge w_clk);
    checkOutput("rst_inReady", in_ready, 0);
    checkOutput("rst_we", write_enable, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wrap", addr_wrap, 0);
    checkOutput("rst_addr", c_address, 0);
    checkOutput("rst_data", w_data, 0);
    reset = 1'b0;

    vecs[0] = '0;
    vecs[0].base = 10'h010; vecs[0].stride = 10'h008; vecs[0].size = 8'd2;
    vecs[0].beats[0] = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[0].beats[1] = {16'd8, 16'd7, 16'd6, 16'd5};
    vecs[0].expAddr = {10'h029, 10'h021, 10'h019, 10'h011, 10'h028, 10'h020, 10'h018, 10'h010};
    vecs[0].expData = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    vecs[1] = '0;
    vecs[1].base = 10'h100; vecs[1].stride = 10'h001; vecs[1].size = 8'd1; vecs[1].relu = 1'b1;
    vecs[1].beats[0] = {16'hFFFF, 16'h0000, 16'd7, 16'hFFFD};
    vecs[1].expAddr[3:0] = {10'h103, 10'h102, 10'h101, 10'h100};
    vecs[1].expData[3:0] = {16'h0000, 16'h0000, 16'd7, 16'h0000};
    vecs[2] = vecs[1];
    vecs[2].relu = 1'b0;
    vecs[2].expData[3:0] = {16'hFFFF, 16'h0000, 16'd7, 16'hFFFD};
    vecs[3] = '0;
    vecs[3].base = 10'h3FC; vecs[3].stride = 10'h002; vecs[3].size = 8'd1;
    vecs[3].beats[0] = {16'd12, 16'd11, 16'd10, 16'd9};
    vecs[3].expAddr[3:0] = {10'h002, 10'h000, 10'h3FE, 10'h3FC};
    vecs[3].expData[3:0] = {16'd12, 16'd11, 16'd10, 16'd9};
    vecs[3].expWrapBit = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].base, vecs[i].stride, vecs[i].size, vecs[i].relu, vecs[i].beats, 0, 1'b0);
      expAddrQ.delete(); expDataQ.delete();
      for (int k = 0; k < 4 * int'(vecs[i].size); k++) begin
        expAddrQ.push_back(vecs[i].expAddr[k]);
        expDataQ.push_back(vecs[i].expData[k]);
      end
      expWrap = vecs[i].expWrapBit;
      compareWrites($sformatf("vec%0d", i));
    end

    // Zero-size fill: done pulse shortly after start, nothing else happens
    capQ.delete(); doneCount = 0; readyCount = 0;
    @(negedge w_clk);
    featuremap_size = 8'd0; base_address = 10'h020; start = 1'b1;
    @(negedge w_clk);
    start = 1'b0;
    t = 0;
    while (doneCount == 0 && t < 2) begin @(negedge w_clk); t++; end
    checkOutput("size0_doneWithin2", (doneCount > 0) ? 1 : 0, 1);
    repeat (4) @(negedge w_clk);
    checkOutput("size0_doneOnce", doneCount, 1);
    checkOutput("size0_noWrites", capQ.size(), 0);
    checkOutput("size0_noReady", readyCount, 0);
    checkOutput("size0_wrapCleared", addr_wrap, 0);

    // Stall in ACCEPT then poke start with new config during WRITE
    bts = '0;
    bts[0] = {$urandom, $urandom};
    bts[1] = {$urandom, $urandom};
    applyStimulus(10'h040, 10'h010, 8'd2, 1'b0, bts, 5, 1'b1);
    buildExpected(10'h040, 10'h010, 8'd2, 1'b0, bts);
    compareWrites("stallPoke");

    // Reset asserted while channel 1 is on the bus
    capQ.delete(); doneCount = 0;
    @(negedge w_clk);
    base_address = 10'h3FF; channel_stride = 10'h001; featuremap_size = 8'd1; relu_en = 1'b0;
    start = 1'b1;
    @(negedge w_clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = {16'd4, 16'd3, 16'd2, 16'd1};
    @(negedge w_clk);
    in_valid = 1'b0;
    checkOutput("midRst_ch0we", write_enable, 1);
    @(negedge w_clk);
    checkOutput("midRst_ch1addr", c_address, 10'h000);
    checkOutput("midRst_wrapBefore", addr_wrap, 1);
    reset = 1'b1;
    #1;
    checkOutput("midRst_we", write_enable, 0);
    checkOutput("midRst_busy", busy, 0);
    checkOutput("midRst_wrap", addr_wrap, 0);
    checkOutput("midRst_addr", c_address, 0);
    checkOutput("midRst_data", w_data, 0);
    capQ.delete();
    repeat (2) @(negedge w_clk);
    reset = 1'b0;
    repeat (4) @(negedge w_clk);
    checkOutput("midRst_noWrites", capQ.size(), 0);
    checkOutput("midRst_idleReady", in_ready, 0);
    checkOutput("midRst_noDone", doneCount, 0);

    for (int it = 0; it < 8; it++) begin
      logic [9:0] b, s;
      logic [7:0] sz;
      logic r;
      b  = 10'($urandom);
      s  = 10'($urandom_range(0, 1023));
      sz = 8'($urandom_range(1, 5));
      r  = 1'($urandom);
      bts = '0;
      for (int p = 0; p < 8; p++) bts[p] = {$urandom, $urandom};
      applyStimulus(b, s, sz, r, bts, int'($urandom_range(0, 2)), 1'b0);
      buildExpected(b, s, sz, r, bts);
      compareWrites($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
